// File: rtl/uart_word_assembler.sv
// Assembles big-endian 16-bit words from a UART byte stream, with an inter-byte timeout.
// Optional tag filtering is enabled by defining UART_TAG_FILTER_EN.
module uart_word_assembler #(
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter logic [3:0]  MAX_TAG        = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done_tick,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t          state_r;
  logic [7:0]      hi_r;
  logic [CW-1:0]   cnt_r;
  logic            tag_bad_s;

  // Decide whether the held high byte carries a tag the demux must not see
`ifdef UART_TAG_FILTER_EN
  always_comb begin
    tag_bad_s = 1'b0;
    if (hi_r[7:4] > MAX_TAG) begin
      tag_bad_s = 1'b1;
    end else begin
      tag_bad_s = 1'b0;
    end
  end
`else
  logic unused_max_tag_s;
  assign unused_max_tag_s = ^MAX_TAG;

  // Without filtering every completed word is forwarded
  always_comb begin
    tag_bad_s = 1'b0;
  end
`endif

  // Framing FSM with registered word, pulses and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hi_r       <= 8'h00;
      cnt_r      <= '0;
      data       <= 16'h0000;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_done_tick) begin
            hi_r    <= rx_byte;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= WAIT_LO;
          end else begin
            busy    <= 1'b0;
          end
        end
        WAIT_LO: begin
          // A byte arriving on the terminal-count cycle still completes the word
          if (rx_done_tick) begin
            if (tag_bad_s) begin
              frame_err  <= 1'b1;
            end else begin
              data       <= {hi_r, rx_byte};
              data_valid <= 1'b1;
            end
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            hi_r      <= 8'h00;
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Scoreboard bench for uart_word_assembler: stimulus pushes expected events, a monitor pops them.
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done_tick = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    bit          ferr;
    logic [15:0] d;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] exp_data = 16'h0000;

  uart_word_assembler #(.TIMEOUT_CYCLES(16), .MAX_TAG(4'h4)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done_tick(rx_done_tick),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output pulse against the head of the expectation queue
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      exp_t e;
      chk("pulse_exclusive", 16'(data_valid & frame_err), 16'h0000);
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_pulse: got dv=%b fe=%b data=%h expected none", data_valid, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind_ferr", 16'(frame_err), 16'(e.ferr));
        chk("sb_data", data, e.d);
      end
    end
  end

  // Called at a negedge; drives the tick for exactly one cycle and returns at the next negedge
  task automatic tick(input logic [7:0] b);
    rx_byte      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_byte      = 8'hA5;
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo, input int gap);
    exp_t e;
    bit   bad;
    bad = 1'b0;
`ifdef UART_TAG_FILTER_EN
    bad = (hi[7:4] > 4'h4);
`endif
    e.ferr = bad;
    e.d    = bad ? exp_data : {hi, lo};
    exp_q.push_back(e);
    tick(hi);
    chk("busy_after_hi", 16'(busy), 16'h0001);
    repeat (gap) begin
      @(negedge clk);
      chk("busy_waiting", 16'(busy), 16'h0001);
    end
    tick(lo);
    if (bad) begin
      chk("filter_ferr", 16'(frame_err), 16'h0001);
      chk("filter_dv", 16'(data_valid), 16'h0000);
      chk("filter_data_held", data, exp_data);
    end else begin
      chk("word_dv", 16'(data_valid), 16'h0001);
      chk("word_ferr", 16'(frame_err), 16'h0000);
      chk("word_data", data, {hi, lo});
      exp_data = {hi, lo};
    end
    chk("busy_after_lo", 16'(busy), 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 16'h0000);
    chk("rst_dv", 16'(data_valid), 16'h0000);
    chk("rst_ferr", 16'(frame_err), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic word, bytes 10 cycles apart
    send_word(8'h31, 8'h2C, 9);
    @(negedge clk);
    chk("dv_single_pulse", 16'(data_valid), 16'h0000);

    // Back-to-back words, no idle gap
    send_word(8'h31, 8'h00, 0);
    send_word(8'h42, 8'h00, 0);
    repeat (3) @(negedge clk);
    chk("b2b_data_held", data, 16'h4200);
    chk("b2b_dv_low", 16'(data_valid), 16'h0000);

    // Timeout after 16 cycles with no low byte
    e.ferr = 1'b1;
    e.d    = exp_data;
    exp_q.push_back(e);
    tick(8'h35);
    repeat (15) @(negedge clk);
    chk("to_no_early_ferr", 16'(frame_err), 16'h0000);
    chk("to_busy_before", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("to_ferr", 16'(frame_err), 16'h0001);
    chk("to_busy_after", 16'(busy), 16'h0000);
    chk("to_data_unchanged", data, 16'h4200);
    @(negedge clk);
    send_word(8'h40, 8'h07, 2);

    // Low byte on the terminal-count cycle wins over the timeout
    send_word(8'h12, 8'h34, 15);
    @(negedge clk);
    chk("tc_no_ferr", 16'(frame_err), 16'h0000);

    // Asynchronous reset while waiting for a low byte
    send_word(8'h31, 8'h2C, 1);
    tick(8'h33);
    chk("pre_rst_busy", 16'(busy), 16'h0001);
    #1 rst = 1'b1;
    #1;
    chk("arst_data", data, 16'h0000);
    chk("arst_busy", 16'(busy), 16'h0000);
    chk("arst_dv", 16'(data_valid), 16'h0000);
    exp_data = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(8'h33, 8'h01, 1);

    // Tag filter: dropped only when the filter is built in
    send_word(8'h9A, 8'hBC, 3);
    send_word(8'h4A, 8'hBC, 3);

    repeat (5) @(negedge clk);
    chk("final_data", data, 16'h4ABC);
    chk("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
